flux_scheduler: RTL and testbench
=================================

# flux_scheduler

Round-robin flux scheduler for the multi-flux HEVC actors in Mulfwd. Each cycle it picks which tagged flux an actor fires, replacing the fixed lowest-index priority loop. Each flux presents a per-flux fire condition (FIFO not-empty/not-full plus local state). The scheduler returns a zero-latency grant, and adds burst limiting, optional grant locking and starvation aging so that no flux is locked out by a busier one.

## Interface
- FLUX, 2: number of tagged fluxes; legal values are 1 and above.
- BURST, 4: maximum consecutive unlocked grants to one flux before the pointer moves on; legal values are 1 and above.
- STARVE_MAX, 64: wait cycles after which a requesting flux becomes starved; must be at least FLUX.
- TAG_W, derived: max(1, $clog2(FLUX)).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- req  in  FLUX  req[i]=1 means flux i can fire this cycle.
- lock  in  FLUX  lock[i]=1 means flux i is mid-operation and must keep the grant while it is owner.
- grant_valid  out  1  a flux fires this cycle.
- grant_tag  out  TAG_W  index of the granted flux; value is don't-care when grant_valid=0.
- grant_onehot  out  FLUX  one-hot grant; all zeros when there is no grant.
- starve  out  FLUX  registered; starve[i]=1 when wait_cnt[i]==STARVE_MAX.

## Operation
- Registers:
  - ptr, TAG_W bits: round-robin search start.
  - owner (TAG_W) and owner_v (1 bit).
  - burst_cnt, $clog2(BURST+1) bits.
  - wait_cnt[FLUX], $clog2(STARVE_MAX+1) bits each.
- Grant selection is combinational, in strict priority order:
  1. Lock: if owner_v and lock[owner]=1, grant owner when req[owner]=1. If req[owner]=0, issue no grant at all (stall); other requests are ignored.
  2. Starvation: otherwise, grant the lowest-index i with req[i]=1 and starve[i]=1.
  3. Round robin: otherwise, grant the first i with req[i]=1 searching ptr, ptr+1, … modulo FLUX.
  4. If req is all zeros: grant_valid=0.
- Update on a cycle with grant g, when the grant was not a lock hold:
  - n = (owner_v and g==owner) ? burst_cnt+1 : 1.
  - If n==BURST: ptr ← (g+1) mod FLUX, burst_cnt ← 0, owner_v ← 0.
  - Else: ptr ← g, burst_cnt ← n, owner ← g, owner_v ← 1.
- Lock-hold grant: ptr, owner and burst_cnt are unchanged. A lock can therefore exceed BURST.
- Lock-stall cycle, or no-grant cycle: ptr is unchanged. On a no-grant cycle without an active lock, owner_v ← 0 and burst_cnt ← 0.
- wait_cnt[i] each cycle:
  - ← 0 if req[i]=0 or i is granted.
  - Otherwise ← min(wait_cnt[i]+1, STARVE_MAX), saturating.
- A lock raised on a flux that is not the current owner has no effect.
- FLUX=1: tag is constant 0; the flux is granted whenever req[0]=1.

## Timing
- Zero latency: grant_* depend combinationally on req and lock in the same cycle. The actor fires in that cycle and reads/writes at the next edge.
- All registers update on the rising clk edge after the grant cycle.
- starve reflects the registered wait_cnt, so it lags one cycle behind the counter increment.
- While rst=1: grant_valid=0 and grant_onehot=0.
- Reset values: ptr=0, owner_v=0, owner=0, burst_cnt=0, all wait_cnt=0, starve=0.
- Reset in the middle of a lock or burst discards it. The first cycle after rst deasserts arbitrates from ptr=0.
- Exactly one grant bit may be set in any cycle. The bench checks $onehot0(grant_onehot) every cycle.

## Structure
- Package flux_pkg holds:
  - function tag_w(int flux), returning max(1, $clog2(flux));
  - localparams for the BURST and STARVE_MAX defaults;
  - shared with remove_h and other Mulfwd actors so their tag widths agree.
- Sub-module rr_pick: purely combinational rotate / find-first-set / unrotate. Inputs are FLUX request bits and a start index; outputs are found, idx and one-hot. It is used once for round robin; starvation uses a plain priority encoder.
- Estimated size: ~200 lines of RTL in total.

## Test plan
- Reset and idle: FLUX=2; rst held 3 cycles with req=2'b11 → grant_valid=0 throughout. First cycle after release grants tag 0.
- Burst fairness: FLUX=2, BURST=4, req=2'b11 held for 16 cycles → tag sequence 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1.
- Round-robin skip: FLUX=4, BURST=1, req=4'b1010 → tags 1,3,1,3; ptr wraps from 3 to 0 and finds 1.
- Lock stall: FLUX=2, flux 0 granted with lock[0]=1, then req[0] dropped for 3 cycles while req[1]=1 → no grant for those 3 cycles. Flux 0 is re-granted when req[0] returns. When lock[0] falls, flux 1 is granted.
- Starvation: FLUX=2, STARVE_MAX=8, lock[0]=1 with req[0]=req[1]=1 for 10 cycles → starve[1]=1 from cycle 9. After lock[0] drops, flux 1 is granted immediately, wait_cnt[1] clears, and starve[1] falls the next cycle.
- Single flux: FLUX=1, random req → grant_valid==req[0] and grant_tag==0 on every cycle.

Source files
------------

// File: rtl/flux_pkg.sv
// Shared definitions for the Mulfwd multi-flux actors: tag width helper,
// scheduler defaults and the grant-source encoding.
package flux_pkg;

  localparam int BURST_DEF      = 4;
  localparam int STARVE_MAX_DEF = 64;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOCK,
    SRC_STARVE,
    SRC_RR
  } grant_src_t;

  function automatic int tag_w(input int flux);
    int w;
    w = $clog2(flux);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/flux_scheduler_rr_pick.sv
// Combinational round-robin pick: rotate requests to the start index,
// find the first set bit, then map it back to an absolute flux index.
module rr_pick
  import flux_pkg::*;
#(
  parameter int FLUX  = 2,
  parameter int TAG_W = tag_w(FLUX)
) (
  input  logic [FLUX-1:0]  req,
  input  logic [TAG_W-1:0] start,
  output logic             found,
  output logic [TAG_W-1:0] idx,
  output logic [FLUX-1:0]  onehot
);

  localparam int unsigned N = FLUX;

  logic [2*FLUX-1:0] dbl;
  logic [FLUX-1:0]   rot;
  int unsigned       ffs;
  int unsigned       pos;

  always_comb begin
    dbl   = {req, req};
    rot   = FLUX'(dbl >> start);
    found = |rot;
    ffs   = 0;
    for (int unsigned k = N; k > 0; k--) begin
      if (rot[k-1]) ffs = k - 1;
    end
    pos = 32'(start) + ffs;
    if (pos >= N) pos = pos - N;
    idx    = TAG_W'(pos);
    onehot = '0;
    for (int unsigned i = 0; i < N; i++) begin
      onehot[i] = found && (pos == i);
    end
  end

endmodule

// File: rtl/flux_scheduler.sv
// Zero-latency flux scheduler: lock hold, then starvation rescue, then
// round robin with burst limiting across FLUX tagged fluxes.
module flux_scheduler
  import flux_pkg::*;
#(
  parameter  int FLUX       = 2,
  parameter  int BURST      = BURST_DEF,
  parameter  int STARVE_MAX = STARVE_MAX_DEF,
  localparam int TAG_W      = tag_w(FLUX)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [FLUX-1:0]  req,
  input  logic [FLUX-1:0]  lock,
  output logic             grant_valid,
  output logic [TAG_W-1:0] grant_tag,
  output logic [FLUX-1:0]  grant_onehot,
  output logic [FLUX-1:0]  starve
);

  localparam int          BC_W = $clog2(BURST + 1);
  localparam int          WC_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned N    = FLUX;

  logic [TAG_W-1:0] ptr;
  logic [TAG_W-1:0] owner;
  logic             owner_v;
  logic [BC_W-1:0]  burst_cnt;
  logic [WC_W-1:0]  wait_cnt [FLUX];

  logic [FLUX-1:0]  owner_oh;
  logic             lock_active;
  logic             owner_req;
  logic [FLUX-1:0]  starve_req;
  logic [TAG_W-1:0] st_idx;
  logic             rr_found;
  logic [TAG_W-1:0] rr_idx;
  logic [FLUX-1:0]  rr_oh;
  grant_src_t       src;
  logic [BC_W-1:0]  burst_next;
  logic [TAG_W-1:0] ptr_after;

  rr_pick #(.FLUX(FLUX), .TAG_W(TAG_W)) u_rr_pick (
    .req    (req),
    .start  (ptr),
    .found  (rr_found),
    .idx    (rr_idx),
    .onehot (rr_oh)
  );

  always_comb begin
    owner_oh = '0;
    starve   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      owner_oh[i] = (owner == TAG_W'(i));
      starve[i]   = (wait_cnt[i] == WC_W'(STARVE_MAX));
    end
    lock_active = owner_v && |(lock & owner_oh);
    owner_req   = |(req & owner_oh);
    starve_req  = req & starve;
    st_idx      = '0;
    for (int unsigned k = N; k > 0; k--) begin
      if (starve_req[k-1]) st_idx = TAG_W'(k - 1);
    end
  end

  // An active lock blocks every other flux even when its owner is not requesting.
  always_comb begin
    src = SRC_NONE;
    if (!rst) begin
      if (lock_active) begin
        if (owner_req) src = SRC_LOCK;
      end else if (|starve_req) begin
        src = SRC_STARVE;
      end else if (rr_found) begin
        src = SRC_RR;
      end
    end
    grant_valid = (src != SRC_NONE);
    case (src)
      SRC_LOCK:   grant_tag = owner;
      SRC_STARVE: grant_tag = st_idx;
      SRC_RR:     grant_tag = rr_idx;
      default:    grant_tag = '0;
    endcase
    grant_onehot = '0;
    if (src == SRC_RR) begin
      grant_onehot = rr_oh;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        grant_onehot[i] = grant_valid && (grant_tag == TAG_W'(i));
      end
    end
    burst_next = (owner_v && grant_tag == owner) ? burst_cnt + 1'b1 : BC_W'(1);
    ptr_after  = (grant_tag == TAG_W'(FLUX - 1)) ? '0 : grant_tag + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      owner     <= '0;
      owner_v   <= 1'b0;
      burst_cnt <= '0;
      for (int unsigned i = 0; i < N; i++) wait_cnt[i] <= '0;
    end else begin
      if (src == SRC_STARVE || src == SRC_RR) begin
        if (burst_next == BC_W'(BURST)) begin
          ptr       <= ptr_after;
          burst_cnt <= '0;
          owner_v   <= 1'b0;
        end else begin
          ptr       <= grant_tag;
          burst_cnt <= burst_next;
          owner     <= grant_tag;
          owner_v   <= 1'b1;
        end
      end else if (src == SRC_NONE && !lock_active) begin
        owner_v   <= 1'b0;
        burst_cnt <= '0;
      end
      for (int unsigned i = 0; i < N; i++) begin
        if (!req[i] || grant_onehot[i]) begin
          wait_cnt[i] <= '0;
        end else if (wait_cnt[i] != WC_W'(STARVE_MAX)) begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_flux_scheduler.sv
// Scoreboard bench for flux_scheduler: three configurations (FLUX=2/4/1)
// driven with directed vectors; a negedge monitor pops and compares.
module tb_flux_scheduler;

  typedef struct {
    int        sel;
    bit        ev;
    int        etag;
    bit        cst;
    logic [1:0] est;
    string     nm;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [1:0] req2 = '0, lock2 = '0, oh2, st2;
  logic       gv2;
  logic [0:0] tag2;
  logic [3:0] req4 = '0, lock4 = '0, oh4, st4;
  logic       gv4;
  logic [1:0] tag4;
  logic [0:0] req1 = '0, lock1 = '0, oh1, st1;
  logic       gv1;
  logic [0:0] tag1;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  flux_scheduler #(.FLUX(2), .BURST(4), .STARVE_MAX(8)) u_d2 (
    .clk(clk), .rst(rst), .req(req2), .lock(lock2), .grant_valid(gv2),
    .grant_tag(tag2), .grant_onehot(oh2), .starve(st2));

  flux_scheduler #(.FLUX(4), .BURST(1), .STARVE_MAX(64)) u_d4 (
    .clk(clk), .rst(rst), .req(req4), .lock(lock4), .grant_valid(gv4),
    .grant_tag(tag4), .grant_onehot(oh4), .starve(st4));

  flux_scheduler #(.FLUX(1), .BURST(4), .STARVE_MAX(64)) u_d1 (
    .clk(clk), .rst(rst), .req(req1), .lock(lock1), .grant_valid(gv1),
    .grant_tag(tag1), .grant_onehot(oh1), .starve(st1));

  task automatic step(input int sel, input bit r, input logic [3:0] rq,
                      input logic [3:0] lk, input bit ev, input int etag,
                      input bit cst, input logic [1:0] est, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r;
    req2 = '0; lock2 = '0; req4 = '0; lock4 = '0; req1 = '0; lock1 = '0;
    case (sel)
      0: begin req2 = rq[1:0]; lock2 = lk[1:0]; end
      1: begin req4 = rq;      lock4 = lk;      end
      default: begin req1 = rq[0:0]; lock1 = lk[0:0]; end
    endcase
    e.sel = sel; e.ev = ev; e.etag = etag; e.cst = cst; e.est = est; e.nm = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   agv;
    int   atag, aoh, eoh;
    vectors++;
    if (!$onehot0(oh2) || !$onehot0(oh4) || !$onehot0(oh1)) begin
      miscompares++;
      $display("FAIL onehot0: oh2=%b oh4=%b oh1=%b required at most one bit each", oh2, oh4, oh1);
    end
    vectors++;
    if (st4 !== 4'b0 || st1 !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_starve: st4=%b st1=%b required zero", st4, st1);
    end
    if (done) begin
      vectors++;
      if (sb.size() != 0) begin
        miscompares++;
        $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
    end else if (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        0: begin agv = gv2; atag = int'(tag2); aoh = int'(oh2); end
        1: begin agv = gv4; atag = int'(tag4); aoh = int'(oh4); end
        default: begin agv = gv1; atag = int'(tag1); aoh = int'(oh1); end
      endcase
      eoh = e.ev ? (1 << e.etag) : 0;
      vectors++;
      if (agv !== e.ev) begin
        miscompares++;
        $display("FAIL %s grant_valid: got %0b required %0b", e.nm, agv, e.ev);
      end
      vectors++;
      if (aoh != eoh) begin
        miscompares++;
        $display("FAIL %s grant_onehot: got %0h required %0h", e.nm, aoh, eoh);
      end
      if (e.ev) begin
        vectors++;
        if (atag != e.etag) begin
          miscompares++;
          $display("FAIL %s grant_tag: got %0d required %0d", e.nm, atag, e.etag);
        end
      end
      if (e.cst) begin
        vectors++;
        if (st2 !== e.est) begin
          miscompares++;
          $display("FAIL %s starve: got %b required %b", e.nm, st2, e.est);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b;
    // Reset with requests pending, then burst fairness.
    repeat (3) step(0, 1, 4'b0011, 4'b0000, 0, 0, 1, 2'b00, "reset");
    for (int i = 0; i < 16; i++) step(0, 0, 4'b0011, 4'b0000, 1, (i / 4) % 2, 1, 2'b00, "burst");
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2'b00, "idle");

    // Lock stall on flux 0, then release with only flux 1 requesting.
    step(0, 0, 4'b0011, 4'b0001, 1, 0, 1, 2'b00, "lock_grant");
    step(0, 0, 4'b0011, 4'b0001, 1, 0, 1, 2'b00, "lock_hold");
    repeat (3) step(0, 0, 4'b0010, 4'b0001, 0, 0, 1, 2'b00, "lock_stall");
    step(0, 0, 4'b0011, 4'b0001, 1, 0, 1, 2'b00, "lock_regrant");
    step(0, 0, 4'b0010, 4'b0000, 1, 1, 1, 2'b00, "lock_release");
    step(0, 0, 4'b0000, 4'b0000, 0, 0, 1, 2'b00, "idle");

    // Starvation of flux 1 behind a long lock on flux 0.
    step(0, 1, 4'b0011, 4'b0001, 0, 0, 1, 2'b00, "rst_pulse");
    for (int k = 1; k <= 10; k++)
      step(0, 0, 4'b0011, 4'b0001, 1, 0, 1, (k >= 9) ? 2'b10 : 2'b00, "starve_build");
    step(0, 0, 4'b0011, 4'b0000, 1, 1, 1, 2'b10, "starve_grant");
    step(0, 0, 4'b0011, 4'b0000, 1, 1, 1, 2'b00, "starve_clear");

    // Reset in the middle of a lock, then a lock on a non-owner.
    step(0, 0, 4'b0011, 4'b0010, 1, 1, 1, 2'b00, "lock_owner1");
    step(0, 1, 4'b0011, 4'b0010, 0, 0, 1, 2'b00, "rst_mid_lock");
    step(0, 0, 4'b0011, 4'b0010, 1, 0, 1, 2'b00, "post_rst");
    step(0, 0, 4'b0011, 4'b0010, 1, 0, 1, 2'b00, "lock_nonowner");

    // FLUX=4, BURST=1 round-robin skip and wrap.
    for (int i = 0; i < 4; i++) step(1, 0, 4'b1010, 4'b0000, 1, (i % 2 == 1) ? 3 : 1, 0, 2'b00, "rr_skip");
    step(1, 0, 4'b0001, 4'b0000, 1, 0, 0, 2'b00, "rr_wrap");
    for (int i = 0; i < 4; i++) step(1, 0, 4'b1111, 4'b0000, 1, (i + 1) % 4, 0, 2'b00, "rr_all");

    // FLUX=1 random requests.
    for (int i = 0; i < 20; i++) begin
      b = 1'($urandom_range(0, 1));
      step(2, 0, {3'b000, b}, 4'b0000, b, 0, 0, 2'b00, "single");
    end

    @(posedge clk);
    #1;
    req1 = '0;
    @(negedge clk);
    #1;
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
